// File: rtl/draw_pkg.sv
// draw_pkg: shared widths and FSM states for the draw arbiter.
// Coordinate/size/colour widths match the rectangle draw engine.
package draw_pkg;

  localparam int X_W  = 8;
  localparam int Y_W  = 7;
  localparam int S_W  = 5;
  localparam int C_W  = 3;
  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ACK  = 2'd3
  } state_e;

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// req_i/ptr_i in -> valid_o (any request), idx_o (first req at or after ptr).
module rr_pick
  import draw_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o
);

  logic [2*N-1:0] rot;
  logic [ID_W:0]  sum;

  // Rotate so that bit 0 is the requester at ptr; the lowest set bit
  // of the rotated vector is the winner.
  always_comb begin
    rot     = {req_i, req_i} >> ptr_i;
    valid_o = |req_i;
    idx_o   = '0;
    sum     = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, ptr_i} + (ID_W + 1)'(j);
        if (sum >= (ID_W + 1)'(N)) begin
          sum = sum - (ID_W + 1)'(N);
        end
        idx_o = sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin owner of the shared rectangle draw engine.
// req + packed rectangles in; eng_* load/enable, plot, ack/err, busy, grant_id out.
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 1100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [X_W*N-1:0] req_x,
  input  logic [Y_W*N-1:0] req_y,
  input  logic [S_W*N-1:0] req_w,
  input  logic [S_W*N-1:0] req_h,
  input  logic [C_W*N-1:0] req_c,
  input  logic             pause,
  input  logic             eng_done,
  output logic             eng_load_n,
  output logic             eng_en,
  output logic [X_W-1:0]   eng_x,
  output logic [Y_W-1:0]   eng_y,
  output logic [S_W-1:0]   eng_w,
  output logic [S_W-1:0]   eng_h,
  output logic [C_W-1:0]   eng_c,
  output logic             plot,
  output logic [N-1:0]     ack,
  output logic             err,
  output logic             busy,
  output logic [ID_W-1:0]  grant_id
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [S_W-1:0]  w_q, w_d;
  logic [S_W-1:0]  h_q, h_d;
  logic [C_W-1:0]  c_q, c_d;
  logic            load_n_q, load_n_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic            pick_vld;
  logic [ID_W-1:0] pick_idx;
  logic [N-1:0]    gnt_hot;

  rr_pick #(.N(N)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      gnt_hot[i] = (gnt_q == ID_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    c_d      = c_q;
    load_n_d = 1'b1;
    ack_d    = '0;
    err_d    = 1'b0;
    wdog_d   = wdog_q;
    eng_en   = 1'b0;
    plot     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld && !pause) begin
          gnt_d = pick_idx;
          for (int i = 0; i < N; i++) begin
            if (pick_idx == ID_W'(i)) begin
              x_d = req_x[i*X_W +: X_W];
              y_d = req_y[i*Y_W +: Y_W];
              w_d = req_w[i*S_W +: S_W];
              h_d = req_h[i*S_W +: S_W];
              c_d = req_c[i*C_W +: C_W];
            end
          end
          load_n_d = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        wdog_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        eng_en = !pause;
        plot   = !pause && !eng_done;
        if (!pause) begin
          wdog_d = wdog_q + 1'b1;
        end
        // done wins over a same-cycle timeout
        if (eng_done) begin
          ack_d   = gnt_hot;
          state_d = ACK;
        end else if (!pause && wdog_q == WD_LAST) begin
          ack_d   = gnt_hot;
          err_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        ptr_d   = (gnt_q == ID_W'(N - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      c_q      <= '0;
      load_n_q <= 1'b1;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      c_q      <= c_d;
      load_n_q <= load_n_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      wdog_q   <= wdog_d;
    end
  end

  assign eng_load_n = load_n_q;
  assign eng_x      = x_q;
  assign eng_y      = y_q;
  assign eng_w      = w_q;
  assign eng_h      = h_q;
  assign eng_c      = c_q;
  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign grant_id   = gnt_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: directed + randomized check of draw_arbiter.
// Behavioural engine and round-robin model live in the bench.
module tb_draw_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 1100;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_x;
  logic [7*N-1:0] req_y;
  logic [5*N-1:0] req_w;
  logic [5*N-1:0] req_h;
  logic [3*N-1:0] req_c;
  logic           pause = 1'b0;
  logic           eng_done;
  logic           eng_load_n;
  logic           eng_en;
  logic [7:0]     eng_x;
  logic [6:0]     eng_y;
  logic [4:0]     eng_w;
  logic [4:0]     eng_h;
  logic [2:0]     eng_c;
  logic           plot;
  logic [N-1:0]   ack;
  logic           err;
  logic           busy;
  logic [2:0]     grant_id;

  logic [7:0] dx [N];
  logic [6:0] dy [N];
  logic [4:0] dw [N];
  logic [4:0] dh [N];
  logic [2:0] dc [N];

  logic       hang = 1'b0;
  logic       drop_all = 1'b0;
  logic [11:0] ecnt = '0;
  int vectors = 0;
  int miscompares = 0;
  int mptr = 0;

  draw_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_c      (req_c),
    .pause      (pause),
    .eng_done   (eng_done),
    .eng_load_n (eng_load_n),
    .eng_en     (eng_en),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_w      (eng_w),
    .eng_h      (eng_h),
    .eng_c      (eng_c),
    .plot       (plot),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_x[8*i +: 8] = dx[i];
      req_y[7*i +: 7] = dy[i];
      req_w[5*i +: 5] = dw[i];
      req_h[5*i +: 5] = dh[i];
      req_c[3*i +: 3] = dc[i];
    end
  end

  // Engine: one pixel per enabled cycle, done once (w+1)*(h+1) are out.
  assign eng_done = !hang &&
    (int'(ecnt) == (int'(eng_w) + 1) * (int'(eng_h) + 1));

  always @(posedge clk) begin
    if (!eng_load_n) ecnt <= '0;
    else if (eng_en && !eng_done) ecnt <= ecnt + 12'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic rand_desc(input int i);
    dx[i] = 8'($urandom);
    dy[i] = 7'($urandom);
    dw[i] = 5'($urandom % 8);
    dh[i] = 5'($urandom % 4);
    dc[i] = 3'($urandom);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_gid"}, 32'(grant_id), 0);
    check({tag, "_loadn"}, 32'(eng_load_n), 1);
    check({tag, "_en"}, 32'(eng_en), 0);
    check({tag, "_plot"}, 32'(plot), 0);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_rect"}, 32'({eng_x, eng_y, eng_w, eng_h, eng_c}), 0);
  endtask

  // One granted rectangle: wait for load, follow RUN to ack, check all.
  task automatic run_txn(input int id, input bit keep, input bit exp_err,
                         input int pz_at, input int pz_len,
                         output int wait_cyc);
    int pix;
    int lows;
    int cyc;
    int epix;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [4:0] ew;
    logic [4:0] eh;
    logic [2:0] ec;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (eng_load_n !== 1'b0 && wait_cyc < 50);
    check("load_seen", 32'(eng_load_n), 0);
    check("grant_id", 32'(grant_id), 32'(id));
    check("busy_load", 32'(busy), 1);
    check("latch_rect", 32'({eng_x, eng_y, eng_w, eng_h, eng_c}),
          32'({dx[id], dy[id], dw[id], dh[id], dc[id]}));
    ex = dx[id]; ey = dy[id]; ew = dw[id]; eh = dh[id]; ec = dc[id];
    epix = exp_err ? TIMEOUT : (int'(ew) + 1) * (int'(eh) + 1);
    rand_desc(id);
    pix = 0;
    lows = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (eng_load_n === 1'b0) lows++;
      if (plot === 1'b1) pix++;
      if (pz_len > 0 && cyc > pz_at && cyc <= pz_at + pz_len) begin
        check("pause_plot", 32'(plot), 0);
        check("pause_en", 32'(eng_en), 0);
      end
      if (pz_len > 0 && cyc == pz_at) pause = 1'b1;
      if (pz_len > 0 && cyc == pz_at + pz_len) pause = 1'b0;
    end while (ack === '0 && cyc < TIMEOUT + 100);
    pause = 1'b0;
    check("ack", 32'(ack), 32'(1) << id);
    check("err", 32'(err), 32'(exp_err));
    check("pixels", 32'(pix), 32'(epix));
    check("load_1cyc", 32'(lows), 0);
    check("rect_stable", 32'({eng_x, eng_y, eng_w, eng_h, eng_c}),
          32'({ex, ey, ew, eh, ec}));
    if (drop_all) req = '0;
    else if (!keep) req[id] = 1'b0;
    mptr = (id + 1) % N;
    @(negedge clk);
    check("ack_pulse", 32'(ack), 0);
    check("err_pulse", 32'(err), 0);
    check("idle_gap", 32'(busy), 0);
  endtask

  initial begin
    int w;
    int e;
    int cnt;
    for (int i = 0; i < N; i++) rand_desc(i);

    // reset state
    @(negedge clk);
    check_reset_outs("rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outs("post_rst");

    // single request, 4x2 rectangle
    dx[2] = 8'd10; dy[2] = 7'd20; dw[2] = 5'd3; dh[2] = 5'd1; dc[2] = 3'd4;
    req = 4'b0100;
    run_txn(2, 1'b0, 1'b0, 0, 0, w);
    check("grant_latency", 32'(w), 1);

    // pointer past 2: {0,1} wraps to 0 then 1
    req = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      e = pick(req, mptr);
      run_txn(e, 1'b0, 1'b0, 0, 0, w);
    end

    // all requesting: strict rotation over 12 rectangles
    req = '1;
    for (int k = 0; k < 12; k++) begin
      drop_all = (k == 11);
      e = pick(req, mptr);
      run_txn(e, 1'b1, 1'b0, 0, 0, w);
    end
    drop_all = 1'b0;

    // pause in IDLE holds off the grant
    pause = 1'b1;
    dw[3] = 5'd7; dh[3] = 5'd3;
    req = 4'b1000;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || eng_load_n !== 1'b1) cnt++;
    end
    check("pause_idle_hold", 32'(cnt), 0);
    // pause for 5 cycles mid-RUN
    pause = 1'b0;
    run_txn(3, 1'b0, 1'b0, 3, 5, w);
    check("resume_latency", 32'(w), 1);

    // hung engine: timeout abort, then next requester served
    hang = 1'b1;
    req = 4'b0011;
    e = pick(req, mptr);
    run_txn(e, 1'b0, 1'b1, 0, 0, w);
    hang = 1'b0;
    e = pick(req, mptr);
    run_txn(e, 1'b0, 1'b0, 0, 0, w);

    // reset mid-RUN: set pointer to 3, start 3, then reset
    req = 4'b0100;
    run_txn(2, 1'b0, 1'b0, 0, 0, w);
    dw[3] = 5'd15; dh[3] = 5'd7;
    req = 4'b1000;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (eng_load_n !== 1'b0 && cnt < 50);
    check("rst_txn_load", 32'(eng_load_n), 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    req = '0;
    #1;
    check_reset_outs("async_rst");
    mptr = 0;
    @(negedge clk);
    check("rst_no_ack", 32'(ack), 0);
    reset = 1'b1;
    req = 4'b1010;
    e = pick(req, mptr);
    run_txn(e, 1'b0, 1'b0, 0, 0, w);
    check("post_rst_latency", 32'(w), 1);
    e = pick(req, mptr);
    run_txn(e, 1'b0, 1'b0, 0, 0, w);

    // randomized request sets, rectangles and pauses
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) rand_desc(i);
      req = 4'($urandom_range(1, 15));
      while (req != '0) begin
        e = pick(req, mptr);
        run_txn(e, 1'b0, 1'b0, 1 + int'($urandom % 3),
                int'($urandom % 3), w);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
